fwrisc_dbus_responder: RTL and testbench
========================================

FWRISC_DBUS_RESPONDER -- requirements
Module: fwrisc_dbus_responder

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024 (power of two, 16..65536), giving backing-store depth in 32-bit words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h8000_0000 (4 KiB aligned), giving the byte address of word 0.
REQ-003 The block SHALL have parameter WAIT_STATES, default 1 (range 0..15), giving extra cycles inserted before each response.
REQ-004 The block SHALL have a port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have a port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have a port dvalid, input, 1 bit: initiator request valid, held high until dready is seen.
REQ-007 The block SHALL have a port daddr, input, 32 bits: request byte address; bits [1:0] are ignored.
REQ-008 The block SHALL have a port dwdata, input, 32 bits: write data, byte lane i = bits [8i+7:8i].
REQ-009 The block SHALL have a port dwstb, input, 4 bits: per-lane write strobes.
REQ-010 The block SHALL have a port dwrite, input, 1 bit: 1 = write, 0 = read.
REQ-011 The block SHALL have a port drdata, output, 32 bits: read data, valid while dready is high.
REQ-012 The block SHALL have a port dready, output, 1 bit: one-cycle response strobe.
REQ-013 The block SHALL have a port addr_err, output, 1 bit: sticky flag, set on any out-of-range access.
REQ-014 The block SHALL have a port proto_err, output, 1 bit: sticky flag, set on dvalid dropped before dready.

Function
REQ-015 The block SHALL implement states IDLE, WAIT and RESP, all outputs registered.
REQ-016 In IDLE, with dvalid=1 at an edge, the block SHALL capture daddr, dwdata, dwstb and dwrite, and go to WAIT, or to RESP if WAIT_STATES=0.
REQ-017 The WAIT state SHALL last exactly WAIT_STATES cycles, counted by a 4-bit counter loaded at capture.
REQ-018 On entry to RESP, dready SHALL be 1 for exactly one cycle, starting WAIT_STATES+1 cycles after the capture edge; the next state SHALL be IDLE.
REQ-019 In range SHALL mean BASE_ADDR <= daddr < BASE_ADDR+4*MEM_WORDS; word index = (daddr-BASE_ADDR)>>2, using captured values only.
REQ-020 An in-range write SHALL update only lanes with dwstb[i]=1, at the edge on which dready rises.
REQ-021 dwstb=4'b0000 with dwrite=1 SHALL leave memory unchanged and still respond.
REQ-022 An in-range read SHALL drive the full 32-bit word on drdata, regardless of dwstb.
REQ-023 drdata SHALL update only at the response edge and hold its value otherwise; a write response SHALL leave drdata unchanged.
REQ-024 An out-of-range access SHALL still respond per REQ-018: reads return 32'h0, writes are dropped, and addr_err is set at the response edge.
REQ-025 If dvalid=0 during WAIT, the block SHALL abort to IDLE without asserting dready or writing memory, and set proto_err.
REQ-026 In IDLE, the block SHALL accept a new request on the cycle after dready with no bubble; dvalid still high in that cycle SHALL be treated as a new request.
REQ-027 Inputs other than dvalid SHALL be ignored outside the IDLE capture edge.

Reset
REQ-028 While reset=0 at an edge, the block SHALL set state=IDLE, dready=0, drdata=0, addr_err=0, proto_err=0 and wait counter=0.
REQ-029 Reset asserted mid-transaction SHALL cancel it: no memory write and no dready.
REQ-030 Memory contents SHALL NOT be cleared by reset; simulation initial content SHALL be 0.

Verification
REQ-031 Scenario: WAIT_STATES=1, write daddr=32'h8000_0010, dwdata=32'hDEAD_BEEF, dwstb=4'hF, then read the same address -> dready two cycles after each capture edge, and the read returns 32'hDEAD_BEEF.
REQ-032 Scenario: byte-lane write dwstb=4'b0100, dwdata=32'h0055_0000 over word 32'h1122_3344 -> readback 32'h1155_3344.
REQ-033 Scenario: read daddr=32'h7FFF_FFFC, and write daddr=32'h8000_1000 with MEM_WORDS=1024 -> both responses occur, read returns 0, memory is unchanged, and addr_err=1.
REQ-034 Scenario: WAIT_STATES=3, drop dvalid in the second WAIT cycle -> no dready, proto_err=1, and the next request completes normally.
REQ-035 Scenario: assert reset=0 one cycle before the response of a pending write -> dready stays 0, the target word is unchanged, and both error flags are 0.
REQ-036 Scenario: WAIT_STATES=0, back-to-back reads with dvalid held high -> dready every second cycle, carrying the correct data each time.

Source files
------------

// File: rtl/fwrisc_dbus_responder.sv
// fwrisc_dbus_responder: word-organised memory that answers the FWRISC data
// bus valid/ready handshake after a fixed number of wait states, flagging
// out-of-range accesses and requests withdrawn before they were answered.
module fwrisc_dbus_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dvalid,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwstb,
  input  logic        dwrite,
  output logic [31:0] drdata,
  output logic        dready,
  output logic        addr_err,
  output logic        proto_err
);

  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [31:0] SPAN      = 32'(MEM_WORDS) << 2;

  typedef enum logic [1:0] { IDLE, WAIT, RESP } state_t;

  state_t           state, state_next;
  logic [3:0]       wait_cnt, wait_cnt_next;
  logic             capture, respond, abort;
  logic [31:0]      req_addr, req_wdata;
  logic [3:0]       req_wstb;
  logic             req_write;
  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] word_idx;

  // Backing store is never cleared by reset; it powers up as all zeros.
  logic [31:0] mem [MEM_WORDS] = '{default: '0};

  // The range test works on the offset so a base near the top of the
  // address space cannot wrap the upper bound.
  assign offset   = req_addr - BASE_ADDR;
  assign in_range = (req_addr >= BASE_ADDR) && (offset < SPAN);
  assign word_idx = offset[IDX_W+1:2];

  // Next-state logic: capture in IDLE, count down the wait states (giving up
  // if the initiator withdraws), then one RESP cycle before the answer edge.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    capture       = 1'b0;
    respond       = 1'b0;
    abort         = 1'b0;
    case (state)
      IDLE: begin
        if (dvalid) begin
          capture       = 1'b1;
          wait_cnt_next = WAIT_INIT;
          state_next    = (WAIT_INIT == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!dvalid) begin
          abort         = 1'b1;
          wait_cnt_next = 4'd0;
          state_next    = IDLE;
        end else if (wait_cnt <= 4'd1) begin
          wait_cnt_next = 4'd0;
          state_next    = RESP;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      RESP: begin
        respond    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and wait counter, cleared by the synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Request fields are latched only at the capture edge and ignored otherwise.
  always_ff @(posedge clock) begin
    if (capture) begin
      req_addr  <= daddr;
      req_wdata <= dwdata;
      req_wstb  <= dwstb;
      req_write <= dwrite;
    end
  end

  // Registered response: ready strobe, read data and the sticky error flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      dready    <= 1'b0;
      drdata    <= '0;
      addr_err  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      dready <= respond;
      if (respond) begin
        if (!in_range) begin
          addr_err <= 1'b1;
          if (!req_write) drdata <= '0;
        end else if (!req_write) begin
          drdata <= mem[word_idx];
        end
      end
      if (abort) proto_err <= 1'b1;
    end
  end

  // Byte-lane write into the store on the edge where dready rises.
  always_ff @(posedge clock) begin
    if (reset && respond && in_range && req_write) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wstb[i]) mem[word_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_fwrisc_dbus_responder.sv
// tb_fwrisc_dbus_responder: three responders (1, 3 and 0 wait states) driven
// by directed requests and checked every cycle against a transaction model.
module tb_fwrisc_dbus_responder;

  typedef struct {
    int          inst;
    int          cycle;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  stb;
  } pend_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        dvalid    [3];
  logic [31:0] daddr     [3];
  logic [31:0] dwdata    [3];
  logic [3:0]  dwstb     [3];
  logic        dwrite    [3];
  logic [31:0] drdata    [3];
  logic        dready    [3];
  logic        addr_err  [3];
  logic        proto_err [3];

  int   cyc      = 0;
  logic rst_seen = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  pend_t       pq [$];
  logic [31:0] mmem [logic [63:0]];
  logic [31:0] exp_drdata  [3];
  logic        exp_aerr    [3];
  logic        exp_proto   [3];
  int          proto_cycle [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fwrisc_dbus_responder #(
      .MEM_WORDS  (1024),
      .BASE_ADDR  (32'h8000_0000),
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 3 : 0))
    ) dut (
      .clock    (clock),
      .reset    (reset),
      .dvalid   (dvalid[g]),
      .daddr    (daddr[g]),
      .dwdata   (dwdata[g]),
      .dwstb    (dwstb[g]),
      .dwrite   (dwrite[g]),
      .drdata   (drdata[g]),
      .dready   (dready[g]),
      .addr_err (addr_err[g]),
      .proto_err(proto_err[g])
    );
  end

  always #5 clock = ~clock;

  // Cycle count and the reset level seen at each rising edge.
  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_seen <= !reset;
  end

  function automatic int ws(int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
  endfunction

  function automatic bit in_range(logic [31:0] a);
    return (a >= 32'h8000_0000) && (a < 32'h8000_1000);
  endfunction

  function automatic logic [63:0] mkey(int inst, logic [31:0] a);
    return {32'(inst), a[31:2], 2'b00};
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Effect of a completed transaction on the model memory and expected outputs.
  function automatic void model_apply(pend_t p);
    logic [63:0] k;
    logic [31:0] w;
    k = mkey(p.inst, p.addr);
    w = mmem.exists(k) ? mmem[k] : 32'h0;
    if (!in_range(p.addr)) begin
      exp_aerr[p.inst] = 1'b1;
      if (!p.wr) exp_drdata[p.inst] = 32'h0;
    end else if (p.wr) begin
      for (int l = 0; l < 4; l++) if (p.stb[l]) w[8*l +: 8] = p.data[8*l +: 8];
      mmem[k] = w;
    end else begin
      exp_drdata[p.inst] = w;
    end
  endfunction

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clock) begin : cmp
    logic exp_rdy;
    if (cyc > 0) begin
      if (rst_seen) begin
        pq.delete();
        for (int i = 0; i < 3; i++) begin
          exp_drdata[i]  = 32'h0;
          exp_aerr[i]    = 1'b0;
          exp_proto[i]   = 1'b0;
          proto_cycle[i] = -1;
        end
      end
      for (int i = 0; i < 3; i++) begin
        exp_rdy = 1'b0;
        if (!rst_seen) begin
          for (int j = pq.size() - 1; j >= 0; j--) begin
            if (pq[j].inst == i && pq[j].cycle == cyc) begin
              exp_rdy = 1'b1;
              model_apply(pq[j]);
              pq.delete(j);
            end
          end
          if (proto_cycle[i] == cyc) exp_proto[i] = 1'b1;
        end
        check_output($sformatf("dready%0d", i), dready[i], exp_rdy);
        check_output($sformatf("drdata%0d", i), drdata[i], exp_drdata[i]);
        check_output($sformatf("addr_err%0d", i), addr_err[i], exp_aerr[i]);
        check_output($sformatf("proto_err%0d", i), proto_err[i], exp_proto[i]);
      end
    end
  end

  // Issue one request at a falling edge and wait (bounded) for its dready.
  task automatic apply_stimulus(input int i, input logic wr, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] stb,
                                input bit keep, output logic [31:0] rdata,
                                output int lat, output int rcyc);
    pend_t p;
    int    start;
    start     = cyc;
    dvalid[i] = 1'b1;
    dwrite[i] = wr;
    daddr[i]  = addr;
    dwdata[i] = data;
    dwstb[i]  = stb;
    p.inst  = i;
    p.cycle = start + ws(i) + 2;
    p.wr    = wr;
    p.addr  = addr;
    p.data  = data;
    p.stb   = stb;
    pq.push_back(p);
    lat   = -1;
    rcyc  = -1;
    rdata = 32'h0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (dready[i]) begin
        lat   = cyc - (start + 1);
        rcyc  = cyc;
        rdata = drdata[i];
        break;
      end
    end
    check_output("resp_seen", 32'(lat >= 0), 32'd1);
    if (!keep) dvalid[i] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat, rc, rc1, rc2, rc3, n, seen;
    for (int i = 0; i < 3; i++) begin
      dvalid[i] = 1'b0; daddr[i] = '0; dwdata[i] = '0; dwstb[i] = '0; dwrite[i] = 1'b0;
      exp_drdata[i] = '0; exp_aerr[i] = 1'b0; exp_proto[i] = 1'b0; proto_cycle[i] = -1;
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      check_output("rst_drdata", drdata[i], 32'h0);
      check_output("rst_dready", 32'(dready[i]), 32'd0);
      check_output("rst_flags", {30'd0, addr_err[i], proto_err[i]}, 32'd0);
    end
    reset = 1'b1;
    @(negedge clock);

    // Full write then read back, two cycles from capture to dready.
    apply_stimulus(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, lat, rc);
    check_output("wr_latency", lat, 32'd2);
    apply_stimulus(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 1'b0, rd, lat, rc);
    check_output("rd_latency", lat, 32'd2);
    check_output("rd_deadbeef", rd, 32'hDEAD_BEEF);

    // Single byte lane, then an all-zero strobe write that must change nothing.
    apply_stimulus(0, 1'b1, 32'h8000_0040, 32'h1122_3344, 4'hF, 1'b0, rd, lat, rc);
    apply_stimulus(0, 1'b1, 32'h8000_0041, 32'h0055_0000, 4'b0100, 1'b0, rd, lat, rc);
    apply_stimulus(0, 1'b0, 32'h8000_0040, 32'h0, 4'h0, 1'b0, rd, lat, rc);
    check_output("lane2_merge", rd, 32'h1155_3344);
    apply_stimulus(0, 1'b1, 32'h8000_0040, 32'hFFFF_FFFF, 4'h0, 1'b0, rd, lat, rc);
    apply_stimulus(0, 1'b0, 32'h8000_0040, 32'h0, 4'h0, 1'b0, rd, lat, rc);
    check_output("zero_strobe", rd, 32'h1155_3344);

    // Out-of-range read below the window and write just past its end.
    apply_stimulus(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'hF, 1'b0, rd, lat, rc);
    check_output("oor_rd_data", rd, 32'h0);
    check_output("oor_addr_err", 32'(addr_err[0]), 32'd1);
    apply_stimulus(0, 1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, lat, rc);
    check_output("oor_wr_latency", lat, 32'd2);
    apply_stimulus(0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 1'b0, rd, lat, rc);
    check_output("oor_no_alias_lo", rd, 32'h0);
    apply_stimulus(0, 1'b0, 32'h8000_0FFC, 32'h0, 4'hF, 1'b0, rd, lat, rc);
    check_output("oor_no_alias_hi", rd, 32'h0);

    // Three wait states; dvalid withdrawn in the second wait cycle.
    n = cyc;
    dvalid[1] = 1'b1; dwrite[1] = 1'b1; daddr[1] = 32'h8000_0020;
    dwdata[1] = 32'h0BAD_F00D; dwstb[1] = 4'hF;
    begin
      pend_t p;
      p.inst = 1; p.cycle = n + 5; p.wr = 1'b1; p.addr = 32'h8000_0020;
      p.data = 32'h0BAD_F00D; p.stb = 4'hF;
      pq.push_back(p);
    end
    @(negedge clock);
    @(negedge clock);
    dvalid[1] = 1'b0;
    for (int j = pq.size() - 1; j >= 0; j--) if (pq[j].inst == 1) pq.delete(j);
    proto_cycle[1] = n + 3;
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (dready[1]) seen++;
    end
    check_output("abort_no_dready", seen, 32'd0);
    check_output("abort_proto_err", 32'(proto_err[1]), 32'd1);
    apply_stimulus(1, 1'b0, 32'h8000_0020, 32'h0, 4'hF, 1'b0, rd, lat, rc);
    check_output("abort_no_write", rd, 32'h0);
    check_output("ws3_latency", lat, 32'd4);
    apply_stimulus(1, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF, 1'b0, rd, lat, rc);
    apply_stimulus(1, 1'b0, 32'h8000_0020, 32'h0, 4'hF, 1'b0, rd, lat, rc);
    check_output("after_abort_rd", rd, 32'hCAFE_F00D);

    // Zero wait states: back-to-back reads with dvalid held high.
    apply_stimulus(2, 1'b1, 32'h8000_0100, 32'hA1A1_A1A1, 4'hF, 1'b0, rd, lat, rc);
    apply_stimulus(2, 1'b1, 32'h8000_0104, 32'hB2B2_B2B2, 4'hF, 1'b0, rd, lat, rc);
    apply_stimulus(2, 1'b1, 32'h8000_0108, 32'hC3C3_C3C3, 4'hF, 1'b0, rd, lat, rc);
    apply_stimulus(2, 1'b0, 32'h8000_0100, 32'h0, 4'hF, 1'b1, rd, lat, rc1);
    check_output("b2b_rd0", rd, 32'hA1A1_A1A1);
    check_output("ws0_latency", lat, 32'd1);
    apply_stimulus(2, 1'b0, 32'h8000_0104, 32'h0, 4'hF, 1'b1, rd, lat, rc2);
    check_output("b2b_rd1", rd, 32'hB2B2_B2B2);
    apply_stimulus(2, 1'b0, 32'h8000_0108, 32'h0, 4'hF, 1'b0, rd, lat, rc3);
    check_output("b2b_rd2", rd, 32'hC3C3_C3C3);
    check_output("b2b_gap01", rc2 - rc1, 32'd2);
    check_output("b2b_gap12", rc3 - rc2, 32'd2);

    // Reset one cycle before the response of a pending write.
    n = cyc;
    dvalid[0] = 1'b1; dwrite[0] = 1'b1; daddr[0] = 32'h8000_0010;
    dwdata[0] = 32'h1234_5678; dwstb[0] = 4'hF;
    begin
      pend_t p;
      p.inst = 0; p.cycle = n + 3; p.wr = 1'b1; p.addr = 32'h8000_0010;
      p.data = 32'h1234_5678; p.stb = 4'hF;
      pq.push_back(p);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    dvalid[0] = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clock);
      if (dready[0]) seen++;
    end
    check_output("rst_cancel_dready", seen, 32'd0);
    check_output("rst_addr_err", 32'(addr_err[0]), 32'd0);
    check_output("rst_proto_err", 32'(proto_err[1]), 32'd0);
    check_output("rst_drdata_clr", drdata[0], 32'h0);
    apply_stimulus(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 1'b0, rd, lat, rc);
    check_output("rst_word_kept", rd, 32'hDEAD_BEEF);

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
